// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: valid/ready register chain with bubble collapse, flush and a registered occupancy count.
module pipe_reg_chain #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);
   logic [DEPTH-1:0] valid, adv, feed;
   logic [WIDTH-1:0] data [DEPTH];
   logic [WIDTH-1:0] src [DEPTH];
   logic free, in_fire;
   // Walk from the output end: a stage may move when everything ahead of it leaves a hole or drains.
   always_comb begin
      free = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         adv[k] = valid[k] && free;
         free = !valid[k] || free;
      end
   end
   assign in_ready = !flush && free;
   assign in_fire = in_valid && in_ready;
   always_comb begin
      feed[0] = in_fire;
      src[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
         feed[k] = adv[k-1];
         src[k] = data[k-1];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
         count <= '0;
         for (int k = 0; k < DEPTH; k++) data[k] <= RESET_VAL;
      end else if (flush) begin
         valid <= '0;
         count <= '0;
      end else begin
         valid <= (valid & ~adv) | feed;
         count <= count + CW'(in_fire) - CW'(adv[DEPTH-1]);
         for (int k = 0; k < DEPTH; k++) if (feed[k]) data[k] <= src[k];
      end
   end
   assign out_valid = valid[DEPTH-1];
   assign out_data = data[DEPTH-1];
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: drives DEPTH=1/3/16 chains with shared stimulus and checks each against an entry-level model.
module tb_pipe_reg_chain;
   localparam logic [15:0] RV = 16'hDEAD;
   logic clk = 0, reset, flush, in_valid, out_ready;
   logic [15:0] in_data;
   logic [2:0] irdy, ov;
   logic [15:0] od [3];
   logic [4:0] cw [3];
   int tests = 0, fails = 0;
   bit started = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int D = g == 0 ? 1 : g == 1 ? 3 : 16;
      logic [$clog2(D+1)-1:0] cnt;
      pipe_reg_chain #(.WIDTH(16), .DEPTH(D), .RESET_VAL(RV)) dut (
         .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irdy[g]),
         .in_data(in_data), .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]), .count(cnt));
      assign cw[g] = 5'(cnt);
   end
   // Model: per depth, a list of live entries (oldest first) with their stage position.
   int dep [3] = '{1, 3, 16};
   int n [3];
   int pos [3][16];
   int npos [3][16];
   logic [15:0] dat [3][16];
   logic [15:0] last [3];
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask
   task automatic plan(input int i, output bit of, output bit ir);
      int lim = dep[i];
      of = n[i] > 0 && pos[i][0] == dep[i] - 1 && out_ready;
      for (int j = of ? 1 : 0; j < n[i]; j++) begin
         npos[i][j] = pos[i][j] + 1 < lim ? pos[i][j] + 1 : pos[i][j];
         lim = npos[i][j];
      end
      ir = !flush && lim > 0;
   endtask
   task automatic compare();
      bit of, ir;
      for (int i = 0; i < 3; i++) begin
         plan(i, of, ir);
         chk($sformatf("out_valid[D%0d]", dep[i]), 32'(ov[i]), 32'(n[i] > 0 && pos[i][0] == dep[i] - 1));
         chk($sformatf("out_data[D%0d]", dep[i]), 32'(od[i]), 32'(last[i]));
         chk($sformatf("count[D%0d]", dep[i]), 32'(cw[i]), 32'(n[i]));
         if (!reset) chk($sformatf("in_ready[D%0d]", dep[i]), 32'(irdy[i]), 32'(ir));
      end
   endtask
   task automatic update();
      bit of, ir;
      int k;
      for (int i = 0; i < 3; i++) begin
         plan(i, of, ir);
         if (reset) begin
            n[i] = 0;
            last[i] = RV;
         end else if (flush) n[i] = 0;
         else begin
            k = 0;
            for (int j = of ? 1 : 0; j < n[i]; j++) begin
               pos[i][k] = npos[i][j];
               dat[i][k] = dat[i][j];
               k++;
            end
            if (in_valid && ir) begin
               pos[i][k] = 0;
               dat[i][k] = in_data;
               k++;
            end
            n[i] = k;
            if (k > 0 && pos[i][0] == dep[i] - 1) last[i] = dat[i][0];
         end
      end
   endtask
   task automatic setin(input bit iv, input logic [15:0] d, input bit ordy, input bit fl, input bit rst);
      in_valid = iv;
      in_data = d;
      out_ready = ordy;
      flush = fl;
      reset = rst;
   endtask
   task automatic cyc(input bit iv, input logic [15:0] d, input bit ordy, input bit fl, input bit rst);
      setin(iv, d, ordy, fl, rst);
      #1;
      if (started) compare();
      @(posedge clk);
      update();
      if (rst) started = 1;
      #1;
   endtask
   initial begin
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 1, 0, 1);
      chk("rst count", 32'(cw[1]), 0);
      chk("rst out_valid", 32'(ov[1]), 0);
      chk("rst out_data", 32'(od[1]), 32'h0000DEAD);
      setin(0, 0, 1, 0, 0);
      #1 chk("in_ready after reset", 32'(irdy[1]), 1);
      cyc(1, 16'hA5, 1, 0, 0);
      chk("single c1 count", 32'(cw[1]), 1);
      chk("single c1 out_valid", 32'(ov[1]), 0);
      cyc(0, 0, 1, 0, 0);
      chk("single c2 count", 32'(cw[1]), 1);
      chk("single c2 out_valid", 32'(ov[1]), 0);
      cyc(0, 0, 1, 0, 0);
      chk("single c3 out_valid", 32'(ov[1]), 1);
      chk("single c3 out_data", 32'(od[1]), 32'hA5);
      cyc(0, 0, 1, 0, 0);
      chk("single c4 count", 32'(cw[1]), 0);
      chk("single c4 out_valid", 32'(ov[1]), 0);
      chk("single c4 data held", 32'(od[1]), 32'hA5);
      for (int v = 1; v <= 10; v++) begin
         cyc(1, 16'(v), 1, 0, 0);
         if (v >= 3) chk($sformatf("stream out_data v%0d", v), 32'(od[1]), 32'(v - 2));
      end
      repeat (20) cyc(0, 0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 2, 0, 0, 0);
      cyc(1, 3, 0, 0, 0);
      chk("full count", 32'(cw[1]), 3);
      chk("full out_data", 32'(od[1]), 1);
      setin(1, 4, 0, 0, 0);
      #1 chk("full in_ready", 32'(irdy[1]), 0);
      cyc(1, 4, 0, 0, 0);
      setin(1, 4, 1, 0, 0);
      #1 chk("full pass-through in_ready", 32'(irdy[1]), 1);
      cyc(1, 4, 1, 0, 0);
      chk("after pass count", 32'(cw[1]), 3);
      chk("after pass out_data", 32'(od[1]), 2);
      repeat (20) cyc(0, 0, 1, 0, 0);
      cyc(1, 7, 0, 0, 0);
      cyc(1, 8, 0, 0, 0);
      setin(1, 9, 0, 1, 0);
      #1 chk("flush in_ready", 32'(irdy[1]), 0);
      cyc(1, 9, 0, 1, 0);
      chk("flush count", 32'(cw[1]), 0);
      chk("flush out_valid", 32'(ov[1]), 0);
      chk("flush data held", 32'(od[1]), 4);
      cyc(1, 16'h11, 0, 0, 0);
      cyc(1, 16'h22, 0, 0, 0);
      cyc(1, 16'h33, 0, 0, 0);
      chk("refill out_data", 32'(od[1]), 32'h11);
      cyc(1, 16'h44, 1, 1, 1);
      chk("reset-over-flush count", 32'(cw[1]), 0);
      chk("reset-over-flush out_valid", 32'(ov[1]), 0);
      chk("reset-over-flush out_data", 32'(od[1]), 32'h0000DEAD);
      setin(0, 0, 1, 0, 0);
      #1 chk("in_ready after mid reset", 32'(irdy[1]), 1);
      repeat (300)
         cyc(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
      repeat (20) cyc(0, 0, 1, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 64, data bits per stage.
REQ-002 Parameter DEPTH, default 3, number of register stages; legal range 1..16.
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data register on reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discards all held entries.
REQ-007 in_valid  input  1  producer offers in_data.
REQ-008 in_ready  output  1  chain accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  producer payload.
REQ-010 out_valid  output  1  last stage holds a valid entry.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 out_data  output  WIDTH  last-stage payload.
REQ-013 count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Stage k (0..DEPTH-1) SHALL hold one valid bit and one WIDTH-bit data register; stage 0 is the input end, stage DEPTH-1 drives out_valid/out_data directly from flops.
REQ-015 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-016 Stage DEPTH-1 SHALL advance (empty itself) on transfer out.
REQ-017 Stage k<DEPTH-1 SHALL advance into stage k+1 when stage k is valid and stage k+1 is empty or advancing in the same cycle (bubble collapse).
REQ-018 in_ready SHALL be 1 when flush is 0 and stage 0 is empty or advancing; in_ready SHALL be 0 whenever flush is 1.
REQ-019 A stage's data register SHALL load only when the stage receives an entry; otherwise it holds its value, including after the entry leaves.
REQ-020 Entries SHALL exit in acceptance order; no entry is duplicated or dropped except by flush or reset.
REQ-021 Latency: with out_ready held 1 and chain empty, an entry accepted at edge N SHALL present out_valid=1 after edge N+DEPTH-1 (DEPTH cycles from the in_valid cycle to the out_valid cycle, inclusive).
REQ-022 Throughput: with out_ready held 1, the chain SHALL sustain one transfer in and one transfer out per cycle indefinitely.
REQ-023 Full (all DEPTH stages valid) with out_ready=0: in_ready=0, all stages hold; the same cycle out_ready=1 SHALL make in_ready=1 (same-cycle pass-through of the freed slot).
REQ-024 flush=1: out_valid/out_data of that cycle are unaffected and a transfer out in that cycle counts; at the next edge every valid bit SHALL clear and count SHALL be 0; data registers hold.
REQ-025 count SHALL equal the number of set valid bits, registered, updating at the same edge as the valid bits; range 0..DEPTH, never wraps.
REQ-026 in_valid while in_ready=0 SHALL have no effect; producer is not required to hold in_valid.

Reset
REQ-027 reset=1 at an edge SHALL clear all valid bits, load RESET_VAL into all data registers, and force count=0, out_valid=0, out_data=RESET_VAL.
REQ-028 reset SHALL take priority over flush and any transfer in the same cycle, including mid-operation with the chain full.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts (flush=0).

Verification
REQ-030 DEPTH=3, out_ready=1, single in_data=0xA5 in cycle 0 -> out_valid=1, out_data=0xA5 in cycle 2 only; count 1,1,1 then 0.
REQ-031 DEPTH=3, out_ready=1, in_data=1,2,3,... every cycle -> out_data 1,2,3,... back-to-back from cycle 2, in_ready constantly 1.
REQ-032 DEPTH=3, out_ready=0, push 1,2,3,4 -> in_ready=0 after 3 accepts, count=3, out_data=1; raise out_ready -> 4 accepted same cycle, drain 1,2,3,4 in order.
REQ-033 Chain holding 2 entries, flush=1 with in_valid=1 -> in_ready=0, new data not accepted, next cycle count=0, out_valid=0.
REQ-034 Chain full, reset=1 and flush=1 and out_ready=1 together -> next cycle count=0, out_valid=0, out_data=RESET_VAL.
REQ-035 DEPTH=1 and DEPTH=16 builds pass REQ-030..REQ-032 with latency 1 and 16 respectively.
